dot4_mac_sequencer: RTL and testbench

//  Downstream consumer of the 16-bit 4:1 operand mux. Drives the mux select, takes the

---
 rtl/dot4_mac_sequencer.sv | 92 +++++++++
 tb/tb_dot4_mac_sequencer.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/dot4_mac_sequencer.sv
// rtl/dot4_mac_sequencer.sv - sequences a 4:1 operand mux and accumulates four products into one dot-product term
// Define DOT4_SIGNED_EN for two's complement operands; the default build multiplies unsigned.
module dot4_mac_sequencer #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 34
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic [1:0]        sel,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic              busy,
   output logic [ACC_W-1:0]  result,
   output logic              result_valid,
   input  logic              result_ready
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t              state;
   logic [ACC_W-1:0]    acc;
   logic [2*DATA_W-1:0] prod_raw;
   logic [ACC_W-1:0]    prod_ext;
   logic [ACC_W-1:0]    acc_next;

`ifdef DOT4_SIGNED_EN
   always_comb begin
      prod_raw = $signed({{DATA_W{a_in[DATA_W-1]}}, a_in}) *
                 $signed({{DATA_W{b_in[DATA_W-1]}}, b_in});
      prod_ext = ACC_W'($signed(prod_raw));
   end
`else
   always_comb begin
      prod_raw = {{DATA_W{1'b0}}, a_in} * {{DATA_W{1'b0}}, b_in};
      prod_ext = ACC_W'(prod_raw);
   end
`endif

   // Operands are only consumed in RUN, so garbage on a_in/b_in elsewhere never reaches state.
   assign acc_next = acc + prod_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         sel          <= 2'd0;
         acc          <= '0;
         result       <= '0;
         result_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               sel <= 2'd0;
               if (start) begin
                  acc   <= '0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               acc <= acc_next;
               if (sel == 2'd3) begin
                  result       <= acc_next;
                  sel          <= 2'd0;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= DONE;
               end else begin
                  sel <= sel + 2'd1;
               end
            end
            DONE: begin
               // Start is only honoured together with acceptance of the held result.
               if (result_ready) begin
                  result_valid <= 1'b0;
                  if (start) begin
                     acc   <= '0;
                     sel   <= 2'd0;
                     busy  <= 1'b1;
                     state <= RUN;
                  end else begin
                     state <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dot4_mac_sequencer.sv
// tb/tb_dot4_mac_sequencer.sv - scoreboard bench for dot4_mac_sequencer with randomized operands and handshakes
module tb_dot4_mac_sequencer;
   localparam int DATA_W = 16;
   localparam int ACC_W  = 34;
   localparam int NT     = 40;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic              result_ready = 1'b0;
   logic [1:0]        sel;
   logic [DATA_W-1:0] a_in, b_in;
   logic              busy, result_valid;
   logic [ACC_W-1:0]  result;

   logic [DATA_W-1:0] av[4], bv[4], nav[4], nbv[4];
   logic [DATA_W-1:0] junk_a = '0, junk_b = '0;
   logic [ACC_W-1:0]  nexp;
   logic [ACC_W-1:0]  exp_q[$];
   int                n_pass = 0, n_total = 0;

   always #5 clk = ~clk;

   assign a_in = busy ? av[sel] : junk_a;
   assign b_in = busy ? bv[sel] : junk_b;

   dot4_mac_sequencer #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .a_in(a_in), .b_in(b_in),
      .busy(busy), .result(result), .result_valid(result_valid), .result_ready(result_ready)
   );

   function automatic void chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
   endfunction

   function automatic logic [ACC_W-1:0] model(input logic [DATA_W-1:0] a[4], input logic [DATA_W-1:0] b[4]);
      longint s = 0;
      for (int i = 0; i < 4; i++) begin
`ifdef DOT4_SIGNED_EN
         s += longint'($signed(a[i])) * longint'($signed(b[i]));
`else
         s += longint'(a[i]) * longint'(b[i]);
`endif
      end
      return ACC_W'(s);
   endfunction

   task automatic gen_vec(input int t);
      for (int i = 0; i < 4; i++) begin
         nav[i] = DATA_W'($urandom);
         nbv[i] = DATA_W'($urandom);
         if ($urandom_range(0, 5) == 0) nav[i] = '1;
         if ($urandom_range(0, 5) == 0) nbv[i] = '1;
      end
      nexp = model(nav, nbv);
      if (t == 0) begin
         for (int i = 0; i < 4; i++) begin
            nav[i] = DATA_W'(i + 1);
            nbv[i] = DATA_W'(i + 5);
         end
         nexp = ACC_W'(70);
      end else if (t == 1) begin
`ifdef DOT4_SIGNED_EN
         nav[0] = -16'sd1; nav[1] = -16'sd2; nav[2] = 16'd3; nav[3] = 16'd4;
         for (int i = 0; i < 4; i++) nbv[i] = 16'd2;
         nexp = ACC_W'(8);
`else
         for (int i = 0; i < 4; i++) begin
            nav[i] = 16'hFFFF;
            nbv[i] = 16'hFFFF;
         end
         nexp = 34'h3_FFF8_0004;
`endif
      end else if (t == 2) begin
`ifdef DOT4_SIGNED_EN
         for (int i = 0; i < 4; i++) begin
            nav[i] = 16'hFFFF;
            nbv[i] = 16'd1;
         end
         nexp = 34'h3_FFFF_FFFC;
`endif
      end
   endtask

   task automatic launch(input bit push);
      av = nav;
      bv = nbv;
      junk_a = DATA_W'($urandom);
      junk_b = DATA_W'($urandom);
      if (push) exp_q.push_back(nexp);
      start = 1'b1;
   endtask

   task automatic run_phase();
      chk("run0_busy", 64'(busy), 64'(1));
      chk("run0_sel", 64'(sel), 64'(0));
      for (int i = 1; i < 4; i++) begin
         @(negedge clk);
         chk("run_sel", 64'(sel), 64'(i));
         chk("run_no_valid", 64'(result_valid), 64'(0));
      end
      @(negedge clk);
      chk("latency_valid", 64'(result_valid), 64'(1));
      chk("done_busy", 64'(busy), 64'(0));
      chk("done_sel", 64'(sel), 64'(0));
   endtask

   initial begin
      bit launched, b2b;
      int hold;
      launched = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset_sel", 64'(sel), 64'(0));
      chk("reset_busy", 64'(busy), 64'(0));
      chk("reset_valid", 64'(result_valid), 64'(0));
      chk("reset_result", 64'(result), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);
      for (int t = 0; t < NT; t++) begin
         if (!launched) begin
            gen_vec(t);
            launch(1'b1);
            @(negedge clk);
            start = 1'b0;
         end
         run_phase();
         hold = (t == 0) ? 10 : $urandom_range(0, 3);
         repeat (hold) begin
            start = $urandom_range(0, 1) == 1;
            @(negedge clk);
            chk("hold_valid", 64'(result_valid), 64'(1));
            chk("hold_busy", 64'(busy), 64'(0));
         end
         start = 1'b0;
         b2b = (t < NT - 1) && (t == 1 || $urandom_range(0, 1) == 1);
         result_ready = 1'b1;
         if (b2b) begin
            gen_vec(t + 1);
            launch(1'b1);
         end
         @(negedge clk);
         result_ready = 1'b0;
         start = 1'b0;
         launched = b2b;
         if (!b2b) begin
            chk("accept_drop_valid", 64'(result_valid), 64'(0));
            chk("accept_idle_busy", 64'(busy), 64'(0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
         end
      end
      gen_vec(5);
      launch(1'b0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      chk("abort_sel_before", 64'(sel), 64'(1));
      #1 rst_n = 1'b0;
      #1;
      chk("abort_sel", 64'(sel), 64'(0));
      chk("abort_busy", 64'(busy), 64'(0));
      chk("abort_valid", 64'(result_valid), 64'(0));
      chk("abort_result", 64'(result), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      gen_vec(0);
      launch(1'b1);
      @(negedge clk);
      start = 1'b0;
      run_phase();
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("queue_empty", 64'(exp_q.size()), 64'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      bit held;
      logic [ACC_W-1:0] hv;
      held = 1'b0;
      hv = '0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            held = 1'b0;
         end else begin
            if (result_valid) begin
               if (held) chk("hold_stable", 64'(result), 64'(hv));
               if (result_ready) begin
                  if (exp_q.size() == 0) begin
                     n_total++;
                     $display("FAIL unexpected_result: got %0h expected none at %0t", result, $time);
                  end else begin
                     chk("result", 64'(result), 64'(exp_q.pop_front()));
                  end
               end
            end
            held = result_valid && !result_ready;
            hv = result;
         end
      end
   end

endmodule
